// File: rtl/ma_stage_inorder_completion.sv
// Memory-access stage: keeps EX instructions in order, pairs in-order read
// returns with their loads, extracts/extends load data and retires into WB.
module ma_stage_inorder_completion #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_load,
  input  logic [1:0]       i_ex_size,
  input  logic             i_ex_unsigned,
  input  logic [2:0]       i_ex_addr_lo,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_we,
  input  logic [XLEN-1:0]  i_ex_alu_result,
  output logic             o_ex_ready,
  input  logic             i_mem_rd_valid,
  input  logic [XLEN-1:0]  i_mem_rd_data,
  input  logic             i_amo_valid,
  input  logic [4:0]       i_amo_rd,
  input  logic [XLEN-1:0]  i_amo_result,
  output logic             o_wb_valid,
  output logic             o_wb_we,
  output logic [4:0]       o_wb_rd,
  output logic [XLEN-1:0]  o_wb_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_amo_pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = (XLEN == 64) ? 3 : 2;

  typedef struct packed {
    logic            ld;
    logic [1:0]      sz;
    logic            uns;
    logic [2:0]      lo;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] alu;
  } entry_t;

  entry_t          r_iq [DEPTH];
  logic [XLEN-1:0] r_dq [DEPTH];
  logic [PW-1:0]   r_iq_wp, r_iq_rp, r_dq_wp, r_dq_rp;
  logic [CNT_W-1:0] r_count, r_dcnt;
  logic            r_amo_pending;
  logic [4:0]      r_amo_rd;
  logic [XLEN-1:0] r_amo_data;
  logic            r_wb_valid, r_wb_we;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;

  entry_t          w_head;
  logic            w_ex_ready, w_enq, w_amo_act, w_retire, w_pop_d;
  logic [AW+2:0]   w_shamt;
  logic [XLEN-1:0] w_shifted, w_load_data;
  logic            w_unused_lo;

  assign w_head     = r_iq[r_iq_rp];
  assign w_ex_ready = (r_count < CNT_W'(DEPTH));
  assign w_enq      = i_ex_valid & w_ex_ready & ~i_stall;
  // A pending AMO drains before a new one could arrive, so it takes priority.
  assign w_amo_act  = ~i_stall & (i_amo_valid | r_amo_pending);
  assign w_retire   = ~i_stall & ~w_amo_act & (r_count != '0) &
                      (~w_head.ld | (r_dcnt != '0));
  assign w_pop_d    = w_retire & w_head.ld;
  assign w_shamt    = {w_head.lo[AW-1:0], 3'b000};
  assign w_shifted  = r_dq[r_dq_rp] >> w_shamt;
  assign w_unused_lo = w_head.lo[2];

  // Load data extraction: select the addressed byte/half/word/double and extend.
  always_comb begin
    w_load_data = w_shifted;
    case (w_head.sz)
      2'd0: w_load_data = w_head.uns ? XLEN'(w_shifted[7:0])  : XLEN'($signed(w_shifted[7:0]));
      2'd1: w_load_data = w_head.uns ? XLEN'(w_shifted[15:0]) : XLEN'($signed(w_shifted[15:0]));
      2'd2: w_load_data = w_head.uns ? XLEN'(w_shifted[31:0]) : XLEN'($signed(w_shifted[31:0]));
      default: begin
        if (XLEN == 64) w_load_data = w_shifted;
        else w_load_data = w_head.uns ? XLEN'(w_shifted[31:0]) : XLEN'($signed(w_shifted[31:0]));
      end
    endcase
  end

  // Queue storage needs no reset; validity comes from the pointers and counts.
  always_ff @(posedge i_clk) begin
    if (w_enq) r_iq[r_iq_wp] <= '{i_ex_is_load, i_ex_size, i_ex_unsigned, i_ex_addr_lo,
                                   i_ex_rd, i_ex_we, i_ex_alu_result};
    if (i_mem_rd_valid) r_dq[r_dq_wp] <= i_mem_rd_data;
  end

  // Instruction queue pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_iq_wp <= '0;
      r_iq_rp <= '0;
      r_count <= '0;
    end else begin
      if (w_enq)    r_iq_wp <= r_iq_wp + 1'b1;
      if (w_retire) r_iq_rp <= r_iq_rp + 1'b1;
      case ({w_enq, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Data queue: every return beat is captured, stalled or not.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dq_wp <= '0;
      r_dq_rp <= '0;
      r_dcnt  <= '0;
    end else begin
      if (i_mem_rd_valid) r_dq_wp <= r_dq_wp + 1'b1;
      if (w_pop_d)        r_dq_rp <= r_dq_rp + 1'b1;
      case ({i_mem_rd_valid, w_pop_d})
        2'b10:   r_dcnt <= r_dcnt + 1'b1;
        2'b01:   r_dcnt <= r_dcnt - 1'b1;
        default: r_dcnt <= r_dcnt;
      endcase
    end
  end

  // AMO result parking while the pipeline is stalled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_amo_pending <= 1'b0;
      r_amo_rd      <= '0;
      r_amo_data    <= '0;
    end else if (i_amo_valid & i_stall) begin
      r_amo_pending <= 1'b1;
      r_amo_rd      <= i_amo_rd;
      r_amo_data    <= i_amo_result;
    end else if (~i_stall) begin
      r_amo_pending <= 1'b0;
    end
  end

  // WB pipeline register: AMO, retiring head, or a bubble.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else if (~i_stall) begin
      if (w_amo_act) begin
        r_wb_valid <= 1'b1;
        r_wb_we    <= 1'b1;
        r_wb_rd    <= r_amo_pending ? r_amo_rd   : i_amo_rd;
        r_wb_data  <= r_amo_pending ? r_amo_data : i_amo_result;
      end else if (w_retire) begin
        r_wb_valid <= 1'b1;
        r_wb_we    <= w_head.we;
        r_wb_rd    <= w_head.rd;
        r_wb_data  <= w_head.ld ? w_load_data : w_head.alu;
      end else begin
        r_wb_valid <= 1'b0;
        r_wb_we    <= 1'b0;
        r_wb_rd    <= '0;
        r_wb_data  <= '0;
      end
    end
  end

  // Protocol checks: data queue overflow and a second AMO while one is parked.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(i_mem_rd_valid && (r_dcnt == CNT_W'(DEPTH)) && !w_pop_d));
      assert (!(i_amo_valid && r_amo_pending));
    end
  end

  assign o_ex_ready    = w_ex_ready;
  assign o_count       = r_count;
  assign o_amo_pending = r_amo_pending;
  assign o_wb_valid    = r_wb_valid;
  assign o_wb_we       = r_wb_we;
  assign o_wb_rd       = r_wb_rd;
  assign o_wb_data     = r_wb_data;

endmodule

// File: tb/tb_ma_stage_inorder_completion.sv
// Directed bench: two instances (XLEN=32 and XLEN=64) share control stimulus.
module tb_ma_stage_inorder_completion;

  logic clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic ex_valid = 1'b0, ex_ld = 1'b0, ex_uns = 1'b0, ex_we = 1'b1;
  logic [1:0] ex_sz = '0;
  logic [2:0] ex_lo = '0;
  logic [4:0] ex_rd = '0, amo_rd = '0;
  logic [63:0] alu = '0, beat = '0, amo_res = '0;
  logic mem_valid = 1'b0, amo_valid = 1'b0;

  logic        rdy32, v32, we32, pend32;
  logic [4:0]  rd32;
  logic [31:0] d32;
  logic [2:0]  cnt32;
  logic        rdy64, v64, we64, pend64;
  logic [4:0]  rd64;
  logic [63:0] d64;
  logic [2:0]  cnt64;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  ma_stage_inorder_completion #(.XLEN(32), .DEPTH(4)) dut32 (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_ex_valid(ex_valid),
    .i_ex_is_load(ex_ld), .i_ex_size(ex_sz), .i_ex_unsigned(ex_uns),
    .i_ex_addr_lo(ex_lo), .i_ex_rd(ex_rd), .i_ex_we(ex_we),
    .i_ex_alu_result(alu[31:0]), .o_ex_ready(rdy32), .i_mem_rd_valid(mem_valid),
    .i_mem_rd_data(beat[31:0]), .i_amo_valid(amo_valid), .i_amo_rd(amo_rd),
    .i_amo_result(amo_res[31:0]), .o_wb_valid(v32), .o_wb_we(we32), .o_wb_rd(rd32),
    .o_wb_data(d32), .o_count(cnt32), .o_amo_pending(pend32));

  ma_stage_inorder_completion #(.XLEN(64), .DEPTH(4)) dut64 (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_ex_valid(ex_valid),
    .i_ex_is_load(ex_ld), .i_ex_size(ex_sz), .i_ex_unsigned(ex_uns),
    .i_ex_addr_lo(ex_lo), .i_ex_rd(ex_rd), .i_ex_we(ex_we),
    .i_ex_alu_result(alu), .o_ex_ready(rdy64), .i_mem_rd_valid(mem_valid),
    .i_mem_rd_data(beat), .i_amo_valid(amo_valid), .i_amo_rd(amo_rd),
    .i_amo_result(amo_res), .o_wb_valid(v64), .o_wb_we(we64), .o_wb_rd(rd64),
    .o_wb_data(d64), .o_count(cnt64), .o_amo_pending(pend64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld;
    logic [1:0]  sz;
    logic        uns;
    logic [2:0]  lo;
    logic [63:0] bt;
    logic [63:0] al;
    logic [31:0] e32;
    logic [63:0] e64;
  } vec_t;

  vec_t tv [10];

  initial begin
    tv[0] = '{1'b1, 2'd0, 1'b0, 3'd3, 64'h0000_0000_80FF_0000, 64'h0, 32'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80};
    tv[1] = '{1'b1, 2'd0, 1'b1, 3'd3, 64'h0000_0000_80FF_0000, 64'h0, 32'h0000_0080, 64'h0000_0000_0000_0080};
    tv[2] = '{1'b1, 2'd1, 1'b0, 3'd2, 64'h0000_0000_80FF_0000, 64'h0, 32'hFFFF_80FF, 64'hFFFF_FFFF_FFFF_80FF};
    tv[3] = '{1'b1, 2'd2, 1'b1, 3'd4, 64'h8765_4321_0000_0000, 64'h0, 32'h0000_0000, 64'h0000_0000_8765_4321};
    tv[4] = '{1'b1, 2'd3, 1'b0, 3'd0, 64'h8765_4321_CAFE_F00D, 64'h0, 32'hCAFE_F00D, 64'h8765_4321_CAFE_F00D};
    tv[5] = '{1'b1, 2'd2, 1'b0, 3'd0, 64'h0000_0000_8000_0001, 64'h0, 32'h8000_0001, 64'hFFFF_FFFF_8000_0001};
    tv[6] = '{1'b1, 2'd1, 1'b1, 3'd6, 64'hBEEF_0000_0000_0000, 64'h0, 32'h0000_0000, 64'h0000_0000_0000_BEEF};
    tv[7] = '{1'b0, 2'd0, 1'b0, 3'd0, 64'h0, 64'h1234_5678_9ABC_DEF0, 32'h9ABC_DEF0, 64'h1234_5678_9ABC_DEF0};
    tv[8] = '{1'b1, 2'd0, 1'b0, 3'd1, 64'h0000_0000_0000_7F00, 64'h0, 32'h0000_007F, 64'h0000_0000_0000_007F};
    tv[9] = '{1'b1, 2'd1, 1'b1, 3'd0, 64'h0000_0000_0000_FFFE, 64'h0, 32'h0000_FFFE, 64'h0000_0000_0000_FFFE};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(cnt32), 64'd0);
    chk("rst_ready", 64'(rdy32), 64'd1);
    chk("rst_wb_valid", 64'(v32), 64'd0);
    chk("rst_wb_data", 64'(d32), 64'd0);
    chk("rst_amo_pend", 64'(pend64), 64'd0);
    @(negedge clk) rst = 1'b0;

    // Three back-to-back non-loads
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ex_valid = (i < 3); ex_ld = 1'b0; ex_rd = 5'(i + 1);
      alu = 64'(8'h11 * (i + 1));
      @(posedge clk); #1;
      if (i >= 1) begin
        chk($sformatf("alu_seq%0d_valid", i), 64'(v32), 64'd1);
        chk($sformatf("alu_seq%0d_data", i), 64'(d32), 64'(8'h11 * i));
        chk($sformatf("alu_seq%0d_rd", i), 64'(rd32), 64'(i));
      end
    end
    chk("alu_seq_count", 64'(cnt32), 64'd0);

    // Extraction table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ex_valid = 1'b1; ex_ld = tv[i].ld; ex_sz = tv[i].sz; ex_uns = tv[i].uns;
      ex_lo = tv[i].lo; ex_rd = 5'(i + 16); alu = tv[i].al;
      beat = tv[i].bt; mem_valid = tv[i].ld;
      @(posedge clk);
      @(negedge clk);
      ex_valid = 1'b0; mem_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_x32", i), 64'(d32), 64'(tv[i].e32));
      chk($sformatf("vec%0d_x64", i), d64, tv[i].e64);
      chk($sformatf("vec%0d_rd", i), 64'(rd64), 64'(i + 16));
    end

    // Load waits for late data; non-load queues behind it
    @(negedge clk);
    ex_valid = 1'b1; ex_ld = 1'b1; ex_sz = 2'd2; ex_uns = 1'b0; ex_lo = '0; ex_rd = 5'd7;
    @(posedge clk);
    @(negedge clk);
    ex_ld = 1'b0; ex_rd = 5'd8; alu = 64'h55;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("late_bubble", 64'(v32), 64'd0);
    chk("late_count", 64'(cnt32), 64'd2);
    repeat (2) @(negedge clk);
    mem_valid = 1'b1; beat = 64'h0000_ABCD;
    @(negedge clk);
    mem_valid = 1'b0;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
        @(posedge clk); #1;
        if (v32) seen = 1'b1;
      end
      chk("late_load_seen", 64'(seen), 64'd1);
    end
    chk("late_load_data", 64'(d32), 64'h0000_ABCD);
    chk("late_load_rd", 64'(rd32), 64'd7);
    @(posedge clk); #1;
    chk("late_alu_data", 64'(d32), 64'h55);
    chk("late_alu_rd", 64'(rd32), 64'd8);

    // Fill with four loads, feed beats under stall, then drain
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ex_valid = 1'b1; ex_ld = 1'b1; ex_sz = 2'd2; ex_uns = 1'b0; ex_lo = '0;
      ex_rd = 5'(10 + i);
      @(posedge clk);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    chk("full_count", 64'(cnt32), 64'd4);
    chk("full_ready", 64'(rdy32), 64'd0);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; beat = 64'(32'h100 + i);
      @(negedge clk);
    end
    mem_valid = 1'b0;
    chk("stall_count", 64'(cnt32), 64'd4);
    chk("stall_wb_valid", 64'(v32), 64'd0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("drain%0d_valid", i), 64'(v32), 64'd1);
      chk($sformatf("drain%0d_data", i), 64'(d32), 64'(32'h100 + i));
      chk($sformatf("drain%0d_rd", i), 64'(rd32), 64'(10 + i));
    end
    chk("drain_count", 64'(cnt32), 64'd0);

    // AMO arriving during a stall, then reset mid-sequence
    @(negedge clk);
    ex_valid = 1'b1; ex_ld = 1'b0; ex_rd = 5'd9; alu = 64'h77;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0; stall = 1'b1; amo_valid = 1'b1; amo_rd = 5'd5; amo_res = 64'hDEAD;
    @(posedge clk); #1;
    chk("amo_pending", 64'(pend32), 64'd1);
    chk("amo_hold_count", 64'(cnt32), 64'd1);
    @(negedge clk);
    amo_valid = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    chk("amo_wb_rd", 64'(rd32), 64'd5);
    chk("amo_wb_data", 64'(d64), 64'hDEAD);
    chk("amo_wb_we", 64'(we32), 64'd1);
    chk("amo_cleared", 64'(pend32), 64'd0);
    @(negedge clk);
    ex_valid = 1'b1; alu = 64'h99; ex_rd = 5'd12;
    @(posedge clk); #1;
    chk("amo_head_rd", 64'(rd32), 64'd9);
    chk("amo_head_data", 64'(d32), 64'h77);
    chk("amo_head_count", 64'(cnt32), 64'd1);
    @(negedge clk);
    ex_valid = 1'b0; stall = 1'b1; amo_valid = 1'b1; amo_rd = 5'd6; amo_res = 64'hBEEF;
    @(posedge clk); #1;
    chk("amo2_pending", 64'(pend64), 64'd1);
    @(negedge clk);
    amo_valid = 1'b0; rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(v32), 64'd0);
    chk("mid_rst_we", 64'(we32), 64'd0);
    chk("mid_rst_rd", 64'(rd32), 64'd0);
    chk("mid_rst_data", d64, 64'd0);
    chk("mid_rst_pend", 64'(pend32), 64'd0);
    chk("mid_rst_count", 64'(cnt32), 64'd0);
    chk("mid_rst_ready", 64'(rdy32), 64'd1);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_no_amo", 64'(v32), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ma_stage_inorder_completion.md
Name: ma_stage_inorder_completion

Overview:
- Next-generation memory-access stage, parametrised for variable-latency data memory.
- Queues every instruction leaving EX in order, together with its load metadata.
- Pairs in-order memory read returns with their loads, then extracts and sign/zero-extends byte/half/word/double.
- Retires results in program order into the WB pipeline register. Holds read returns and AMO results that arrive during stalls, so no data depends on fixed BRAM latency.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- DEPTH, 4, maximum instructions in flight between EX and WB (power of 2, ≥2).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_stall  in  1  pipeline stall; freezes enqueue, retire and the WB register
- i_ex_valid  in  1  instruction presented by EX
- i_ex_is_load  in  1  instruction is a load or LR (expects one memory return)
- i_ex_size  in  2  0=byte 1=half 2=word 3=double (3 treated as word when XLEN=32)
- i_ex_unsigned  in  1  zero-extend loaded data
- i_ex_addr_lo  in  3  low address bits; [1:0] used when XLEN=32
- i_ex_rd  in  5  destination register
- i_ex_we  in  1  regfile write enable
- i_ex_alu_result  in  XLEN  result for non-loads
- o_ex_ready  out  1  queue can accept an instruction
- i_mem_rd_valid  in  1  read data beat valid (returns in issue order)
- i_mem_rd_data  in  XLEN  raw memory word
- i_amo_valid  in  1  AMO old-value result available (one-cycle pulse)
- i_amo_rd  in  5  AMO destination
- i_amo_result  in  XLEN  AMO old value
- o_wb_valid  out  1  WB register holds a retired instruction
- o_wb_we  out  1  WB regfile write enable
- o_wb_rd  out  5  WB destination
- o_wb_data  out  XLEN  WB write data
- o_count  out  CNT_W  instruction-queue occupancy
- o_amo_pending  out  1  AMO result held waiting for a stall to end

Behaviour:
- Reset (async, any cycle, including mid-operation):
  - Both FIFOs emptied; o_count=0; o_ex_ready=1.
  - o_wb_valid=0, o_wb_we=0, o_wb_rd=0, o_wb_data=0, o_amo_pending=0.
  - In-flight returns are discarded.
- Instruction FIFO (DEPTH entries): o_ex_ready = (o_count<DEPTH), driven from the registered count only, with no same-cycle dequeue bypass. Enqueue occurs when i_ex_valid & o_ex_ready & ~i_stall.
- Data FIFO (DEPTH entries): every i_mem_rd_valid beat is written, including while stalled. Overflow is impossible by construction; a write while full is a simulation assertion failure.
- Head retirement (when ~i_stall and no AMO action this cycle):
  - Non-load head: retires.
  - Load head: retires only if the data FIFO is non-empty; it then pops one data beat.
  - Retire loads the WB register: o_wb_valid=1, rd/we from the entry.
  - Data is the ALU result for a non-load, or extract(beat) for a load.
  - A head load waiting for data, or an empty queue, loads a bubble: o_wb_valid=0, o_wb_we=0.
- extract: shift the beat right by addr_lo×8 (addr_lo[1:0] at XLEN=32), take 8/16/32/64 bits, then sign-extend, or zero-extend if unsigned, to XLEN.
- Latency:
  - Enqueue at edge t into an empty queue gives o_wb_valid at edge t+1 for a non-load.
  - A load whose data beat arrives in cycle c appears in WB at edge c+2.
  - Throughput is one retire per cycle.
- Stall: the WB register, the head and the count all hold. Memory beats still accumulate.
- AMO:
  - i_amo_valid & ~i_stall: WB register ← {valid=1, we=1, rd=i_amo_rd, data=i_amo_result}; the head does not retire that cycle.
  - i_amo_valid & i_stall: save into the pending slot; o_amo_pending=1.
  - First ~i_stall cycle with pending: WB ← saved values, pending cleared, head does not retire.
  - i_amo_valid while pending=1 is an assertion failure.
- Simultaneous enqueue and retire: the count is unchanged. Read/write pointers wrap modulo DEPTH. Correct wrap is required at full (o_ex_ready=0 until a retire).

Test Plan:
- Reset, 3 non-loads (ALU 0x11, 0x22, 0x33, rd 1/2/3), no stall → o_wb_data 0x11, 0x22, 0x33 on consecutive cycles; o_count returns to 0.
- XLEN=32: LB addr_lo=3 with beat 0x80FF_0000 → 0xFFFF_FF80. Same with LBU → 0x0000_0080. LH addr_lo=2 → 0xFFFF_80FF.
- XLEN=64: LW unsigned addr_lo=4 with beat 0x8765_4321_0000_0000 → 0x0000_0000_8765_4321. LD → full beat.
- Load then non-load; memory data arrives 3 cycles late → the non-load waits behind the load; WB order is load, then non-load; a bubble is seen while waiting.
- DEPTH=4: fill 4 loads → o_ex_ready=0. Assert stall, deliver 4 beats → the data FIFO holds all 4. Release stall → 4 correct retires on 4 consecutive cycles.
- AMO pulse rd=5 result 0xDEAD during stall → o_amo_pending=1. Release stall → WB shows rd=5/0xDEAD first, then the head. Assert reset mid-sequence → all outputs return to 0 immediately.
